// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions: active-low segment patterns ({g,f,e,d,c,b,a})
// used by both the display encoder and the readback decoder, plus the readback FSM states.
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0011000;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_B     = 7'b0000011;
  localparam logic [6:0] SEG_C     = 7'b1000110;
  localparam logic [6:0] SEG_D     = 7'b0100001;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_F     = 7'b0001110;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Readback scan states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_e;

  // Forward encoding used by the display path; the readback decoder is its inverse.
  function automatic logic [6:0] seg_encode(input logic [3:0] nib);
    logic [6:0] pat;
    case (nib)
      4'h0: pat = SEG_0;
      4'h1: pat = SEG_1;
      4'h2: pat = SEG_2;
      4'h3: pat = SEG_3;
      4'h4: pat = SEG_4;
      4'h5: pat = SEG_5;
      4'h6: pat = SEG_6;
      4'h7: pat = SEG_7;
      4'h8: pat = SEG_8;
      4'h9: pat = SEG_9;
      4'hA: pat = SEG_A;
      4'hB: pat = SEG_B;
      4'hC: pat = SEG_C;
      4'hD: pat = SEG_D;
      4'hE: pat = SEG_E;
      default: pat = SEG_F;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/seg7_readback_if.sv
// Signal bundle for the seven-segment readback block: segment bus and start in,
// busy/valid strobes, decoded word, error mask and debug state out.
// Handshake: start is a level sampled every cycle and only acted on while idle;
// valid is a one-cycle pulse in which dig/err_mask are freshly updated, and busy
// covers every cycle from the one after start is accepted up to and including valid.
interface seg7_readback_if #(
  parameter int NUM_DIGITS = 8
);
  import seg7_pkg::*;

  logic [7*NUM_DIGITS-1:0] seg;
  logic                    start;
  logic                    busy;
  logic                    valid;
  logic [4*NUM_DIGITS-1:0] dig;
  logic [NUM_DIGITS-1:0]   err_mask;
  state_e                  state;

  // Requester side: drives the segment bus and start, observes results.
  modport master (
    output seg,
    output start,
    input  busy,
    input  valid,
    input  dig,
    input  err_mask,
    input  state
  );

  // Readback block side.
  modport slave (
    input  seg,
    input  start,
    output busy,
    output valid,
    output dig,
    output err_mask,
    output state
  );

endinterface

// File: rtl/seg7_pattern_decode.sv
// Combinational inverse of the seven-segment encoder: any pattern that is not
// one of the 16 hex glyphs (blank included) decodes to 0 with err set.
module seg7_pattern_decode (
  input  logic [6:0] pattern,
  output logic [3:0] nibble,
  output logic       err
);
  import seg7_pkg::*;

  // Pattern lookup with an error default for unknown glyphs.
  always_comb begin
    nibble = 4'h0;
    err    = 1'b0;
    case (pattern)
      SEG_0: nibble = 4'h0;
      SEG_1: nibble = 4'h1;
      SEG_2: nibble = 4'h2;
      SEG_3: nibble = 4'h3;
      SEG_4: nibble = 4'h4;
      SEG_5: nibble = 4'h5;
      SEG_6: nibble = 4'h6;
      SEG_7: nibble = 4'h7;
      SEG_8: nibble = 4'h8;
      SEG_9: nibble = 4'h9;
      SEG_A: nibble = 4'hA;
      SEG_B: nibble = 4'hB;
      SEG_C: nibble = 4'hC;
      SEG_D: nibble = 4'hD;
      SEG_E: nibble = 4'hE;
      SEG_F: nibble = 4'hF;
      default: begin
        nibble = 4'h0;
        err    = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/seg7_readback.sv
// Seven-segment readback: scans the active-low segment bus one digit at a time,
// waits for each digit to hold STABLE_CYCLES identical samples (or gives up after
// TIMEOUT_CYCLES), decodes it, and publishes the word plus error mask with a valid pulse.
module seg7_readback #(
  parameter int NUM_DIGITS     = 8,
  parameter int STABLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                    iCLK,
  input  logic                    iRST_N,
  input  logic [7*NUM_DIGITS-1:0] iSEG,
  input  logic                    iSTART,
  output logic                    oBUSY,
  output logic                    oVALID,
  output logic [4*NUM_DIGITS-1:0] oDIG,
  output logic [NUM_DIGITS-1:0]   oERR_MASK,
  output seg7_pkg::state_e        oSTATE
);
  import seg7_pkg::*;

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CW-1:0] STB_LIM  = CW'(STABLE_CYCLES);
  localparam logic [CW-1:0] TMO_LIM  = CW'(TIMEOUT_CYCLES);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

  state_e                  state_q,  state_d;
  logic [IW-1:0]           idx_q,    idx_d;
  logic [6:0]              pat_q,    pat_d;
  logic [CW-1:0]           stable_q, stable_d;
  logic [CW-1:0]           tmo_q,    tmo_d;
  logic [4*NUM_DIGITS-1:0] dig_sh_q, dig_sh_d;
  logic [NUM_DIGITS-1:0]   err_sh_q, err_sh_d;
  logic [4*NUM_DIGITS-1:0] dig_q,    dig_d;
  logic [NUM_DIGITS-1:0]   err_q,    err_d;

  logic [6:0]    seg_slice;
  logic [3:0]    dec_nib;
  logic          dec_err;
  logic [CW-1:0] stable_n;
  logic [CW-1:0] tmo_n;
  logic          resolve;
  logic [3:0]    res_nib;
  logic          res_err;

  // Select the segment slice of the digit currently being scanned.
  always_comb begin
    seg_slice = iSEG[int'(idx_q)*7 +: 7];
  end

  // The pattern register is the only decode source: a digit resolves on
  // stability only when the live slice matches it.
  seg7_pattern_decode u_decode (
    .pattern (pat_q),
    .nibble  (dec_nib),
    .err     (dec_err)
  );

  // Next-state, per-digit counters, shadow accumulation and output capture.
  // A stable count of zero marks the first cycle on a fresh digit.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    pat_d    = pat_q;
    stable_d = stable_q;
    tmo_d    = tmo_q;
    dig_sh_d = dig_sh_q;
    err_sh_d = err_sh_q;
    dig_d    = dig_q;
    err_d    = err_q;
    stable_n = '0;
    tmo_n    = '0;
    resolve  = 1'b0;
    res_nib  = 4'h0;
    res_err  = 1'b0;

    case (state_q)
      IDLE: begin
        if (iSTART) begin
          state_d  = SCAN;
          idx_d    = '0;
          stable_d = '0;
          tmo_d    = '0;
          dig_sh_d = '0;
          err_sh_d = '0;
        end
      end

      SCAN: begin
        if (stable_q == '0) begin
          pat_d    = seg_slice;
          stable_n = CW'(1);
          tmo_n    = CW'(1);
        end else begin
          tmo_n = (tmo_q >= TMO_LIM) ? TMO_LIM : tmo_q + CW'(1);
          if (seg_slice == pat_q) begin
            stable_n = (stable_q >= STB_LIM) ? STB_LIM : stable_q + CW'(1);
          end else begin
            pat_d    = seg_slice;
            stable_n = CW'(1);
          end
        end
        stable_d = stable_n;
        tmo_d    = tmo_n;

        // Stability is checked first so it wins a same-cycle tie with timeout.
        if (stable_n >= STB_LIM) begin
          resolve = 1'b1;
          res_nib = dec_nib;
          res_err = dec_err;
        end else if (tmo_n >= TMO_LIM) begin
          resolve = 1'b1;
          res_nib = 4'h0;
          res_err = 1'b1;
        end

        if (resolve) begin
          dig_sh_d[int'(idx_q)*4 +: 4] = res_nib;
          err_sh_d[idx_q]              = res_err;
          stable_d                     = '0;
          tmo_d                        = '0;
          if (idx_q == IDX_LAST) begin
            idx_d   = '0;
            state_d = DONE;
            dig_d   = dig_sh_d;
            err_d   = err_sh_d;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any scan and clears results.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      pat_q    <= '0;
      stable_q <= '0;
      tmo_q    <= '0;
      dig_sh_q <= '0;
      err_sh_q <= '0;
      dig_q    <= '0;
      err_q    <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      pat_q    <= pat_d;
      stable_q <= stable_d;
      tmo_q    <= tmo_d;
      dig_sh_q <= dig_sh_d;
      err_sh_q <= err_sh_d;
      dig_q    <= dig_d;
      err_q    <= err_d;
    end
  end

  // Status outputs decoded straight from the state register.
  always_comb begin
    oBUSY     = (state_q != IDLE);
    oVALID    = (state_q == DONE);
    oDIG      = dig_q;
    oERR_MASK = err_q;
    oSTATE    = state_q;
  end

endmodule

// File: tb/tb_seg7_readback.sv
// Directed bench for seg7_readback: expected word, error mask and busy length
// are pushed when a scan is launched; a negedge monitor pops and compares on oVALID.
module tb_seg7_readback;
  import seg7_pkg::*;

  localparam int ND  = 8;
  localparam int STB = 4;
  localparam int TMO = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  seg7_readback_if #(.NUM_DIGITS(ND)) bus ();

  seg7_readback #(
    .NUM_DIGITS     (ND),
    .STABLE_CYCLES  (STB),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .iCLK      (clk),
    .iRST_N    (rst_n),
    .iSEG      (bus.seg),
    .iSTART    (bus.start),
    .oBUSY     (bus.busy),
    .oVALID    (bus.valid),
    .oDIG      (bus.dig),
    .oERR_MASK (bus.err_mask),
    .oSTATE    (bus.state)
  );

  // ---------------- scoreboard state ----------------
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [47:0] exp_q[$];          // {busy_cycles[7:0], err_mask[7:0], dig[31:0]}
  longint      valid_cyc[$];
  int          busy_cnt = 0;
  logic [47:0] mon_e;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Spec glyph table, written out independently of the design package.
  function automatic logic [6:0] seg_of(input logic [3:0] n);
    case (n)
      4'h0: return 7'b1000000;
      4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;
      4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;
      4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;
      4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0011000;
      4'hA: return 7'b0001000;
      4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;
      4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;
      default: return 7'b0001110;
    endcase
  endfunction

  function automatic logic [7*ND-1:0] enc_word(input logic [31:0] w);
    logic [7*ND-1:0] r;
    for (int k = 0; k < ND; k++) r[7*k +: 7] = seg_of(w[4*k +: 4]);
    return r;
  endfunction

  function automatic logic [47:0] mk_exp(input logic [31:0] d, input logic [7:0] e, input int lat);
    return {8'(lat), e, d};
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (!rst_n) begin
      busy_cnt = 0;
    end else begin
      if (bus.busy) busy_cnt++;
      if (bus.valid) begin
        valid_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          check("unexpected_valid", 64'(exp_q.size()), 64'd1);
        end else begin
          mon_e = exp_q.pop_front();
          check("dig", 64'(bus.dig), 64'(mon_e[31:0]));
          check("err_mask", 64'(bus.err_mask), 64'(mon_e[39:32]));
          check("busy_cycles", 64'(busy_cnt), 64'(mon_e[47:40]));
        end
      end
      if (!bus.busy) busy_cnt = 0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic start_scan();
    @(posedge clk);
    #1 bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!bus.busy) begin
        ok = 1'b1;
        break;
      end
    end
    check(name, 64'(ok), 64'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got time %0t expected < 2000000", $time);
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [7*ND-1:0] w;
    bit ok;
    int nv;
    int base;

    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.seg   = '1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_valid", 64'(bus.valid), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_dig", 64'(bus.dig), 64'd0);
    check("rst_err", 64'(bus.err_mask), 64'd0);
    check("rst_state", 64'(bus.state), 64'(IDLE));

    // Static word.
    bus.seg = enc_word(32'h1234ABCD);
    exp_q.push_back(mk_exp(32'h1234ABCD, 8'h00, 33));
    start_scan();
    wait_idle("static_done");

    // Digit 3 blank, all others 8.
    w = enc_word(32'h88880888);
    w[27:21] = 7'b1111111;
    bus.seg = w;
    exp_q.push_back(mk_exp(32'h88880888, 8'h08, 33));
    start_scan();
    wait_idle("blank_done");

    // Digit 0 toggles 1/7 every cycle -> times out after TMO cycles.
    bus.seg = enc_word(32'hFEDCBA90);
    exp_q.push_back(mk_exp(32'hFEDCBA90, 8'h01, TMO + 7 * STB + 1));
    start_scan();
    bus.seg[6:0] = seg_of(4'h1);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk);
      #1;
      if (!bus.busy) begin
        ok = 1'b1;
        break;
      end
      bus.seg[6:0] = (bus.seg[6:0] == seg_of(4'h1)) ? seg_of(4'h7) : seg_of(4'h1);
    end
    check("toggle_done", 64'(ok), 64'd1);

    // Digit 2 holds 5 for two samples, glitches to 3 once, then settles on 5.
    bus.seg = enc_word(32'h1234A5C0);
    exp_q.push_back(mk_exp(32'h1234A5C0, 8'h00, 36));
    start_scan();
    repeat (10) @(posedge clk);
    #1 bus.seg[20:14] = seg_of(4'h3);
    @(posedge clk);
    #1 bus.seg[20:14] = seg_of(4'h5);
    wait_idle("glitch_done");

    // Reset pulse mid-scan: no result, outputs cleared, then a clean scan.
    bus.seg = enc_word(32'hDEADBEEF);
    start_scan();
    repeat (10) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("midrst_dig", 64'(bus.dig), 64'd0);
    check("midrst_err", 64'(bus.err_mask), 64'd0);
    check("midrst_valid", 64'(bus.valid), 64'd0);
    check("midrst_busy", 64'(bus.busy), 64'd0);
    check("midrst_state", 64'(bus.state), 64'(IDLE));
    #4 rst_n = 1'b1;
    exp_q.push_back(mk_exp(32'hDEADBEEF, 8'h00, 33));
    start_scan();
    wait_idle("postrst_done");

    // Start held high: three scans spaced 34 cycles apart.
    bus.seg = enc_word(32'h02468ACE);
    for (int i = 0; i < 3; i++) exp_q.push_back(mk_exp(32'h02468ACE, 8'h00, 33));
    base = valid_cyc.size();
    @(posedge clk);
    #1 bus.start = 1'b1;
    nv = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (bus.valid) nv++;
      if (nv == 3) begin
        bus.start = 1'b0;
        break;
      end
    end
    bus.start = 1'b0;
    check("b2b_count", 64'(nv), 64'd3);
    wait_idle("b2b_done");
    if (valid_cyc.size() >= base + 3) begin
      check("b2b_gap1", 64'(valid_cyc[base+1] - valid_cyc[base]), 64'd34);
      check("b2b_gap2", 64'(valid_cyc[base+2] - valid_cyc[base+1]), 64'd34);
    end else begin
      check("b2b_valid_seen", 64'(valid_cyc.size() - base), 64'd3);
    end
    repeat (5) @(negedge clk);
    check("b2b_stays_idle", 64'(bus.busy), 64'd0);

    check("exp_q_drained", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
